// File: rtl/game_pkg.sv
// Shared game constants and the collision-checker state encoding.
package game_pkg;

  localparam int SCREEN_WIDTH_DEF  = 400;
  localparam int SCREEN_HEIGHT_DEF = 600;
  // Edge length of one safe-zone map cell, in pixels.
  localparam int BLOCK_SIZE        = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_PROBE    = 2'd2,
    ST_DONE     = 2'd3
  } zc_state_e;

endpackage

// File: rtl/zone_collision_checker.sv
// Probes the four corners of the player box against the safe-zone map,
// one corner per cycle, and reports whether all / any corner is safe.
// A map-not-ready cycle during probing throws away the partial result and
// restarts from corner 0 once the map is ready again.
module zone_collision_checker
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int PLAYER_SIZE   = 20
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic                             i_start,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  i_px,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] i_py,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_all_safe,
  output logic                             o_any_safe,
  input  logic                             i_map_rdy,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  o_map_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] o_map_y,
  input  logic                             i_map_is_safe
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);

  // Corner math runs one bit wider so px+S-1 can never wrap.
  localparam logic [XW:0] X_MAX = (XW+1)'(SCREEN_WIDTH - 1);
  localparam logic [YW:0] Y_MAX = (YW+1)'(SCREEN_HEIGHT - 1);
  localparam logic [XW:0] X_OFF = (XW+1)'(PLAYER_SIZE - 1);
  localparam logic [YW:0] Y_OFF = (YW+1)'(PLAYER_SIZE - 1);

  zc_state_e       state, state_nx;
  logic [1:0]      k;
  logic [XW-1:0]   px_q;
  logic [YW-1:0]   py_q;
  logic            acc_all, acc_any;

  logic [XW:0]     x_near_w, x_far_w;
  logic [YW:0]     y_near_w, y_far_w;
  logic [XW-1:0]   x_near, x_far, corner_x;
  logic [YW-1:0]   y_near, y_far, corner_y;
  logic [1:0]      sel;

  // Near/far edges of the box, clamped to the last pixel of the playfield.
  always_comb begin
    x_near_w = {1'b0, px_q};
    y_near_w = {1'b0, py_q};
    x_far_w  = {1'b0, px_q} + X_OFF;
    y_far_w  = {1'b0, py_q} + Y_OFF;
    x_near   = (x_near_w > X_MAX) ? X_MAX[XW-1:0] : x_near_w[XW-1:0];
    y_near   = (y_near_w > Y_MAX) ? Y_MAX[YW-1:0] : y_near_w[YW-1:0];
    x_far    = (x_far_w  > X_MAX) ? X_MAX[XW-1:0] : x_far_w[XW-1:0];
    y_far    = (y_far_w  > Y_MAX) ? Y_MAX[YW-1:0] : y_far_w[YW-1:0];
  end

  // Corner to load next: corner 0 when entering PROBE, else the one after k.
  // Index bit 0 picks the right edge, bit 1 the bottom edge.
  always_comb begin
    sel      = (state == ST_PROBE) ? k + 2'd1 : 2'd0;
    corner_x = sel[0] ? x_far : x_near;
    corner_y = sel[1] ? y_far : y_near;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (i_start) state_nx = ST_WAIT_RDY;
      ST_WAIT_RDY: if (i_map_rdy) state_nx = ST_PROBE;
      ST_PROBE: begin
        if (!i_map_rdy)     state_nx = ST_WAIT_RDY;
        else if (k == 2'd3) state_nx = ST_DONE;
      end
      ST_DONE:     state_nx = i_start ? ST_WAIT_RDY : ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  assign o_busy = (state == ST_WAIT_RDY) || (state == ST_PROBE);
  assign o_done = (state == ST_DONE);

  // Capture, corner sequencing, accumulation and result registers.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      k          <= 2'd0;
      px_q       <= '0;
      py_q       <= '0;
      acc_all    <= 1'b1;
      acc_any    <= 1'b0;
      o_all_safe <= 1'b0;
      o_any_safe <= 1'b0;
      o_map_x    <= '0;
      o_map_y    <= '0;
    end else begin
      if ((state == ST_IDLE || state == ST_DONE) && i_start) begin
        px_q <= i_px;
        py_q <= i_py;
      end
      if (state == ST_WAIT_RDY && i_map_rdy) begin
        o_map_x <= corner_x;
        o_map_y <= corner_y;
        k       <= 2'd0;
        acc_all <= 1'b1;
        acc_any <= 1'b0;
      end
      if (state == ST_PROBE) begin
        if (!i_map_rdy) begin
          k <= 2'd0;
        end else if (k == 2'd3) begin
          // Last corner: publish, keep corner 3 on the map port.
          o_all_safe <= acc_all & i_map_is_safe;
          o_any_safe <= acc_any | i_map_is_safe;
          acc_all    <= acc_all & i_map_is_safe;
          acc_any    <= acc_any | i_map_is_safe;
        end else begin
          acc_all <= acc_all & i_map_is_safe;
          acc_any <= acc_any | i_map_is_safe;
          o_map_x <= corner_x;
          o_map_y <= corner_y;
          k       <= k + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_zone_collision_checker.sv
// Bench for zone_collision_checker: a cell-grid safe map answers queries,
// a table of boxes/maps plus random runs are checked against a model that
// works from corner geometry and the map-ready history.
module tb_zone_collision_checker;
  import game_pkg::*;

  localparam int W   = 400;
  localparam int H   = 600;
  localparam int S   = 20;
  localparam int BLK = BLOCK_SIZE;
  localparam int CW  = W / BLK;
  localparam int CH  = H / BLK;

  logic       clk = 1'b0;
  logic       arst_n, i_start, i_map_rdy, i_map_is_safe;
  logic       o_busy, o_done, o_all_safe, o_any_safe;
  logic [8:0] i_px, o_map_x;
  logic [9:0] i_py, o_map_y;

  bit safe_map [0:CW-1][0:CH-1];
  bit rdy_s [0:127];
  int noise_mode;
  int errs = 0;
  int checks = 0;

  zone_collision_checker #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .PLAYER_SIZE(S)) dut (
    .clk(clk), .arst_n(arst_n), .i_start(i_start), .i_px(i_px), .i_py(i_py),
    .o_busy(o_busy), .o_done(o_done), .o_all_safe(o_all_safe), .o_any_safe(o_any_safe),
    .i_map_rdy(i_map_rdy), .o_map_x(o_map_x), .o_map_y(o_map_y), .i_map_is_safe(i_map_is_safe)
  );

  always #5 clk = ~clk;

  assign i_map_is_safe = safe_map[int'(o_map_x) / BLK][int'(o_map_y) / BLK];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: all safe, 1: all unsafe, 2: all safe except cell (ucx,ucy), 3: random
  task automatic set_map(input int mode, input int ucx, input int ucy);
    for (int x = 0; x < CW; x++)
      for (int y = 0; y < CH; y++) begin
        case (mode)
          0: safe_map[x][y] = 1'b1;
          1: safe_map[x][y] = 1'b0;
          2: safe_map[x][y] = !(x == ucx && y == ucy);
          default: safe_map[x][y] = ($urandom_range(0, 9) < 6);
        endcase
      end
  endtask

  task automatic rdy_all_high();
    for (int c = 0; c < 128; c++) rdy_s[c] = 1'b1;
  endtask

  task automatic launch(input int px, input int py);
    i_px = 9'(px);
    i_py = 10'(py);
    i_start = 1'b1;
    i_map_rdy = rdy_s[0];
    tick();
  endtask

  // Runs from cycle 1 after the start cycle until o_done, then checks timing,
  // queried corners, busy and results. With chain set, a new start is issued
  // in the done cycle.
  task automatic follow(input int px, input int py, input bit chain, input int npx, input int npy);
    int exp_t, t;
    int mx [0:127];
    int my [0:127];
    int cx [4];
    int cy [4];
    bit busy_ok, exp_all, exp_any, ok;
    // Done arrives once the map was ready for a full wait+4-probe window.
    exp_t = -1;
    for (int c = 6; c < 120 && exp_t < 0; c++) begin
      ok = 1'b1;
      for (int j = c - 5; j < c; j++) if (!rdy_s[j]) ok = 1'b0;
      if (ok) exp_t = c;
    end
    exp_all = 1'b1;
    exp_any = 1'b0;
    for (int q = 0; q < 4; q++) begin
      cx[q] = px + (((q & 1) != 0) ? S - 1 : 0);
      cy[q] = py + (((q & 2) != 0) ? S - 1 : 0);
      if (cx[q] > W - 1) cx[q] = W - 1;
      if (cy[q] > H - 1) cy[q] = H - 1;
      exp_all = exp_all & safe_map[cx[q] / BLK][cy[q] / BLK];
      exp_any = exp_any | safe_map[cx[q] / BLK][cy[q] / BLK];
    end
    t = -1;
    busy_ok = 1'b1;
    for (int c = 1; c < 120; c++) begin
      mx[c] = int'(o_map_x);
      my[c] = int'(o_map_y);
      if (o_done) begin
        t = c;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
      case (noise_mode)
        1: begin
          i_start = 1'($urandom_range(0, 1));
          i_px = 9'($urandom_range(0, W - 1));
          i_py = 10'($urandom_range(0, H - 1));
        end
        2: begin
          i_start = (c == 3);
          i_px = 9'd0;
          i_py = 10'd0;
        end
        default: i_start = 1'b0;
      endcase
      i_map_rdy = rdy_s[c];
      tick();
    end
    chk("done_cycle", t, exp_t);
    chk("busy_while_checking", busy_ok, 1);
    chk("busy_low_in_done", o_busy, 0);
    chk("all_safe", o_all_safe, exp_all);
    chk("any_safe", o_any_safe, exp_any);
    if (t >= 5) begin
      for (int q = 0; q < 4; q++) begin
        chk($sformatf("corner%0d_x", q), mx[t - 4 + q], cx[q]);
        chk($sformatf("corner%0d_y", q), my[t - 4 + q], cy[q]);
      end
    end
    i_map_rdy = 1'b1;
    if (chain) begin
      i_start = 1'b1;
      i_px = 9'(npx);
      i_py = 10'(npy);
      tick();
      chk("start_in_done_busy", o_busy, 1);
      chk("start_in_done_no_done", o_done, 0);
    end else begin
      i_start = 1'b0;
      tick();
      chk("done_one_cycle", o_done, 0);
      chk("all_hold", o_all_safe, exp_all);
      chk("any_hold", o_any_safe, exp_any);
    end
    i_start = 1'b0;
  endtask

  typedef struct {
    int px, py, mode, ucx, ucy;
    bit e_all, e_any;
    int e_c3x, e_c3y;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    tbl[0] = '{100, 200, 0,  0,  0, 1'b1, 1'b1, 119, 219};
    tbl[1] = '{100, 200, 2, 11, 21, 1'b0, 1'b1, 119, 219};
    tbl[2] = '{390, 590, 0,  0,  0, 1'b1, 1'b1, 399, 599};
    tbl[3] = '{100, 200, 1,  0,  0, 1'b0, 1'b0, 119, 219};
    tbl[4] = '{  0,   0, 2,  0,  0, 1'b0, 1'b1,  19,  19};
    tbl[5] = '{390, 590, 2, 39, 59, 1'b0, 1'b0, 399, 599};
    tbl[6] = '{380, 580, 2, 39, 59, 1'b0, 1'b1, 399, 599};

    noise_mode = 0;
    set_map(0, 0, 0);
    rdy_all_high();
    arst_n = 1'b0;
    i_start = 1'b1;
    i_px = 9'd77;
    i_py = 10'd88;
    i_map_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_all", o_all_safe, 0);
    chk("rst_any", o_any_safe, 0);
    chk("rst_map_x", o_map_x, 0);
    chk("rst_map_y", o_map_y, 0);
    arst_n = 1'b1;
    i_start = 1'b0;
    tick();
    chk("post_rst_idle", o_busy, 0);

    // Table of boxes and maps.
    for (int i = 0; i < 7; i++) begin
      set_map(tbl[i].mode, tbl[i].ucx, tbl[i].ucy);
      rdy_all_high();
      launch(tbl[i].px, tbl[i].py);
      follow(tbl[i].px, tbl[i].py, 1'b0, 0, 0);
      chk($sformatf("tbl%0d_all", i), o_all_safe, tbl[i].e_all);
      chk($sformatf("tbl%0d_any", i), o_any_safe, tbl[i].e_any);
      chk($sformatf("tbl%0d_hold_x", i), o_map_x, tbl[i].e_c3x);
      chk($sformatf("tbl%0d_hold_y", i), o_map_y, tbl[i].e_c3y);
    end

    // Map drops out for 3 cycles starting at the k=2 probe.
    set_map(2, 11, 21);
    rdy_all_high();
    rdy_s[4] = 1'b0;
    rdy_s[5] = 1'b0;
    rdy_s[6] = 1'b0;
    launch(100, 200);
    follow(100, 200, 1'b0, 0, 0);

    // Start pulsed mid-probe is ignored; start in the done cycle is taken.
    set_map(0, 0, 0);
    rdy_all_high();
    noise_mode = 2;
    launch(100, 200);
    follow(100, 200, 1'b1, 200, 300);
    noise_mode = 0;
    follow(200, 300, 1'b0, 0, 0);

    // Reset while probing corner 1.
    launch(150, 250);
    i_start = 1'b0;
    tick();
    tick();
    arst_n = 1'b0;
    i_start = 1'b1;
    tick();
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_all", o_all_safe, 0);
    chk("midrst_any", o_any_safe, 0);
    chk("midrst_map_x", o_map_x, 0);
    chk("midrst_map_y", o_map_y, 0);
    tick();
    arst_n = 1'b1;
    i_start = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (o_done || o_busy) seen++;
    end
    chk("midrst_quiet", seen, 0);

    // Random boxes, maps, ready drop-outs and ignored starts.
    noise_mode = 1;
    for (int r = 0; r < 30; r++) begin
      int px, py;
      set_map(3, 0, 0);
      for (int c = 0; c < 128; c++) rdy_s[c] = ($urandom_range(0, 9) != 0);
      for (int c = 90; c < 128; c++) rdy_s[c] = 1'b1;
      px = $urandom_range(0, W - 1);
      py = $urandom_range(0, H - 1);
      launch(px, py);
      follow(px, py, 1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
